// File: rtl/des_pkg.sv
// DES constants, permutation helpers and FSM encoding.
// Tables use DES numbering: entry n selects input bit n counted from the MSB.
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Right-rotate amounts for decryption, round index 0..15.
  localparam logic [1:0] SHIFT_T [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Flat S-box store indexed by {box, row, col}.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++)
      y = {y[62:0], x[6'(64 - IP_T[6'(j)])]};
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++)
      y = {y[62:0], x[6'(64 - FP_T[6'(j)])]};
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++)
      y = {y[46:0], x[5'(32 - E_T[6'(j)])]};
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 32; j++)
      y = {y[30:0], x[5'(32 - P_T[5'(j)])]};
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++)
      y = {y[54:0], x[6'(64 - PC1_T[6'(j)])]};
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++)
      y = {y[46:0], x[6'(56 - PC2_T[6'(j)])]};
    return y;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      b = 6'(x >> (42 - 6 * i));
      y = {y[27:0], 4'(SBOX[{3'(i), b[5], b[0], b[4:1]}])};
    end
    return y;
  endfunction

  function automatic logic [27:0] rotr28(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/round.sv
// One combinational DES Feistel round on a {L,R} block.
// L' = R, R' = L ^ P(S(E(R) ^ K)).
module round
  import des_pkg::*;
(
  input  logic [63:0] blk_i,
  input  logic [47:0] key_i,
  output logic [63:0] blk_o
);

  logic [31:0] l;
  logic [31:0] r;
  logic [31:0] f;

  assign l     = blk_i[63:32];
  assign r     = blk_i[31:0];
  assign f     = p_perm(sbox(e_exp(r) ^ key_i));
  assign blk_o = {r, l ^ f};

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative single-DES decryptor, one Feistel round per clock.
// Key halves rotate right so subkeys come out K16 first.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext_i,
  input  logic [63:0] key_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext_o,
  output logic        busy
);

  state_e      st_q;
  logic [3:0]  cnt_q;
  logic [63:0] blk_q;
  logic [63:0] pt_q;
  logic [27:0] c_q;
  logic [27:0] d_q;

  logic        last;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [27:0] c_d;
  logic [27:0] d_d;
  logic [47:0] sk;
  logic [63:0] blk_d;

  assign last  = (cnt_q == 4'd15);
  assign c_rot = rotr28(c_q, SHIFT_T[cnt_q]);
  assign d_rot = rotr28(d_q, SHIFT_T[cnt_q]);
  assign sk    = pc2({c_rot, d_rot});

  // Schedule sums to 27; one extra step restores the PC-1 halves.
  assign c_d = last ? rotr28(c_rot, 2'd1) : c_rot;
  assign d_d = last ? rotr28(d_rot, 2'd1) : d_rot;

  round u_round (
    .blk_i (blk_q),
    .key_i (sk),
    .blk_o (blk_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      pt_q  <= '0;
      c_q   <= '0;
      d_q   <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (in_valid) begin
            st_q       <= S_RUN;
            cnt_q      <= '0;
            blk_q      <= ip(ciphertext_i);
            {c_q, d_q} <= pc1(key_i);
          end
        end
        S_RUN: begin
          blk_q <= blk_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            st_q <= S_DONE;
            pt_q <= fp({blk_d[31:0], blk_d[63:32]});
          end
        end
        S_DONE: begin
          if (out_ready) st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (st_q == S_IDLE);
  assign out_valid   = (st_q == S_DONE);
  assign busy        = (st_q != S_IDLE);
  assign plaintext_o = pt_q;

endmodule
